// File: rtl/reg_18_rx.sv
// reg_18_rx -- serial-to-parallel receiver, the far end of the 18-bit shift-out link.
//
// Collects LSB-first serial bits into a WIDTH-bit word and parks the finished
// word in a one-entry output buffer. Downstream logic takes it through a
// valid/ready handshake. A word that finishes while the buffer is still
// occupied (and not being taken that same cycle) is dropped, and a sticky
// Overrun flag records the loss.
//
// Ports:
//   Clk          system clock, rising edge
//   Reset        synchronous, active-high; overrides everything
//   Start        one-cycle frame-start pulse (also restarts a frame in flight)
//   Bit_En       bit strobe; Serial_In is captured when high
//   Serial_In    serial data, LSB first
//   Data_Ready   downstream takes Data_Out this cycle
//   Clr_Overrun  clears Overrun (a new overrun in the same cycle wins)
//   Data_Out     buffered word
//   Data_Valid   Data_Out holds a word not yet taken
//   Busy         frame in progress
//   Overrun      sticky: a completed word was dropped
module reg_18_rx #(
   parameter int WIDTH = 18            // 2..31, bounded by the 5-bit counter
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Bit_En,
   input  logic             Serial_In,
   input  logic             Data_Ready,
   input  logic             Clr_Overrun,
   output logic [WIDTH-1:0] Data_Out,
   output logic             Data_Valid,
   output logic             Busy,
   output logic             Overrun
);

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;

   logic             complete;
   logic             accept;
   logic [WIDTH-1:0] candidate;

   // The incoming bit enters at the top, so after WIDTH shifts the first bit
   // received sits in bit 0.
   assign candidate = {Serial_In, shift_q[WIDTH-1:1]};
   assign accept    = valid_q & Data_Ready;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   // Frame sequencing. Start always wins over a coincident Bit_En, and the
   // shift register is never cleared on Start: stale bits are shifted out
   // before the frame completes, so they cannot reach the output.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (Start) begin
               cnt_d = '0;
            end else if (Bit_En) begin
               shift_d = candidate;
               if (cnt_q == CNT_LAST) begin
                  complete = 1'b1;
                  state_d  = IDLE;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output buffer and overrun tracking. A word being taken this cycle frees
   // the slot in time for a word completing on the same edge.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (Clr_Overrun) ovr_d = 1'b0;
      if (complete) begin
         if (!valid_q || accept) begin
            data_d  = candidate;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (accept) begin
         valid_d = 1'b0;
      end
   end

   assign Data_Out   = data_q;
   assign Data_Valid = valid_q;
   assign Busy       = (state_q == SHIFT);
   assign Overrun    = ovr_q;

endmodule

// File: doc/reg_18_rx.md
Name: reg_18_rx

Overview:
- Serial-to-parallel receiver; the far end of the 18-bit shift-out link.
- Assembles LSB-first serial bits into an 18-bit word and holds it in a one-word output buffer.
- Presents the word to downstream final-project logic through a valid/ready handshake.
- Flags words lost because downstream logic did not accept the previous one in time.

Parameters:
- WIDTH, 18, word length in bits; supported range 2..31 (bit counter is 5 bits).

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle frame-start pulse; arms reception.
- Bit_En  input  1  bit strobe; Serial_In is sampled on rising Clk when high.
- Serial_In  input  1  serial data, LSB first.
- Data_Ready  input  1  downstream accepts Data_Out this cycle.
- Clr_Overrun  input  1  clears the sticky Overrun flag.
- Data_Out  output  WIDTH  buffered received word.
- Data_Valid  output  1  Data_Out holds an unaccepted word.
- Busy  output  1  frame in progress (state SHIFT).
- Overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Synchronous active-high reset, priority over everything:
  - state IDLE, bit count 0, shift register 0.
  - Data_Out 0, Data_Valid 0, Busy 0, Overrun 0.
- FSM states:
  - IDLE: Bit_En ignored. Start -> SHIFT with count=0; the shift register is not cleared.
  - SHIFT: Busy=1. On each Bit_En: shift <= {Serial_In, shift[WIDTH-1:1]}, count++.
  - Completion: Bit_En with count==WIDTH-1 ends the frame -> IDLE, count=0.
- Start in SHIFT: restarts the frame. Count=0, partial bits are discarded, and no word is produced.
- Start and Bit_En in the same cycle: Start wins. Serial_In is not sampled that cycle.
- Word transfer on the completion cycle:
  - The candidate word is {Serial_In, shift[WIDTH-1:1]}.
  - Buffer free (Data_Valid=0), or being accepted this cycle (Data_Valid & Data_Ready): Data_Out <= candidate, Data_Valid <= 1.
  - Buffer full and not accepted: candidate dropped, Data_Out unchanged, Overrun <= 1.
- Latency: Data_Valid rises on the clock edge that samples the WIDTH-th bit. It is visible in the following cycle.
- Handshake:
  - Data_Valid & Data_Ready with no completion: Data_Valid <= 0. Data_Out holds its last value.
  - Data_Ready while Data_Valid=0: no effect.
  - Data_Out is stable whenever Data_Valid=1 until acceptance.
- Overrun:
  - Cleared by Clr_Overrun or Reset.
  - If a new overrun and Clr_Overrun occur in the same cycle, set wins.
- Bit_En may be any duty cycle, including every cycle. Gaps between strobes are unbounded.
- Bit order: the first serial bit lands in Data_Out[0]. This is the exact inverse of a right-shifting, Shift_Out=bit0 transmitter.

Test Plan:
- Reset, then Start, then 18 back-to-back Bit_En strobes carrying 18'h2A5C3 LSB-first -> Data_Valid=1 the cycle after the 18th strobe, Data_Out=18'h2A5C3, Busy=0, Overrun=0.
- Same frame with 3 idle cycles between every strobe, Data_Ready held 0, then Data_Ready for 1 cycle -> word 18'h2A5C3 held stable through the wait, Data_Valid drops after acceptance.
- Two frames 18'h00001 then 18'h3FFFF, with no Data_Ready between them -> Data_Out stays 18'h00001, Overrun=1. After Clr_Overrun, Overrun=0.
- Data_Ready asserted in exactly the completion cycle of the second frame -> Data_Out=18'h3FFFF, Data_Valid stays 1, Overrun=0.
- Start, 9 bits, then Start again, then a full frame of 18'h15555 -> only 18'h15555 is delivered, no spurious word.
- Reset asserted mid-frame after 10 bits -> all outputs 0 next cycle. A subsequent full frame 18'h0F0F0 is received correctly.
